// File: rtl/hpdcache_sram_sweeper.sv
// hpdcache_sram_sweeper: drives an HPDcache single-port SRAM with an INIT_VALUE write sweep
// after reset or on request, then passes functional requests straight through to the macro.
// Optional read-back verify pass enabled by defining HPDCACHE_SRAM_SWEEP_VERIFY_EN.
module hpdcache_sram_sweeper #(
  parameter int ADDR_SIZE = 0,
  parameter int DATA_SIZE = 0,
  parameter int DEPTH = 2 ** ADDR_SIZE,
  parameter logic [((DATA_SIZE < 1) ? 1 : DATA_SIZE)-1:0] INIT_VALUE = '0,
  parameter bit INIT_ON_RESET = 1'b1,
  // Sizes of 0 are placeholders; clamp so an unconfigured elaboration stays well-formed
  localparam int Aw = (ADDR_SIZE < 1) ? 1 : ADDR_SIZE,
  localparam int Dw = (DATA_SIZE < 1) ? 1 : DATA_SIZE
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init_req,
  output logic          init_busy,
  output logic          init_done,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [Aw-1:0] req_addr,
  input  logic [Dw-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [Dw-1:0] rsp_rdata,
  output logic          sram_cs,
  output logic          sram_we,
  output logic [Aw-1:0] sram_addr,
  output logic [Dw-1:0] sram_wdata,
  input  logic [Dw-1:0] sram_rdata,
  output logic          err,
  output logic [Aw-1:0] err_addr
);

  localparam logic [Aw-1:0] LastAddr = Aw'(DEPTH - 1);

  typedef enum logic [2:0] {StStart, StWr, StRd, StChk, StReady} state_e;

  state_e        state_q, state_d;
  logic [Aw-1:0] cnt_q, cnt_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          cnt_last;
  logic          accept;

  // Wrap by compare so non-power-of-two depths work
  assign cnt_last = (cnt_q == LastAddr);
  assign accept   = (state_q == StReady) && req_valid && !init_req;

`ifdef HPDCACHE_SRAM_SWEEP_VERIFY_EN
  logic          chk_vld_q, chk_vld_d;
  logic [Aw-1:0] chk_addr_q, chk_addr_d;
  logic          err_q, err_d;
  logic [Aw-1:0] err_addr_q, err_addr_d;

  // Verify-pass state: address of the read in flight and the sticky first-mismatch record
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_vld_q  <= 1'b0;
      chk_addr_q <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      chk_vld_q  <= chk_vld_d;
      chk_addr_q <= chk_addr_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Compare the read issued last cycle; only the first mismatch is recorded
  always_comb begin
    chk_vld_d  = (state_q == StRd);
    chk_addr_d = cnt_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if ((state_q == StReady) && init_req) begin
      err_d      = 1'b0;
      err_addr_d = '0;
    end else if (chk_vld_q && !err_q && (sram_rdata != INIT_VALUE)) begin
      err_d      = 1'b1;
      err_addr_d = chk_addr_q;
    end
  end

  assign err      = err_q;
  assign err_addr = err_addr_q;
`else
  assign err      = 1'b0;
  assign err_addr = '0;
`endif

  // State register, sweep counter and read-response flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT_ON_RESET ? StStart : StReady;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = accept && !req_we;
    case (state_q)
      StStart: state_d = StWr;
      StWr: begin
        if (cnt_last) begin
          cnt_d = '0;
`ifdef HPDCACHE_SRAM_SWEEP_VERIFY_EN
          state_d = StRd;
`else
          state_d = StReady;
`endif
        end else begin
          cnt_d = cnt_q + Aw'(1);
        end
      end
`ifdef HPDCACHE_SRAM_SWEEP_VERIFY_EN
      StRd: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = StChk;
        end else begin
          cnt_d = cnt_q + Aw'(1);
        end
      end
      StChk: state_d = StReady;
`endif
      StReady: if (init_req) state_d = StStart;
      default: state_d = StReady;
    endcase
  end

  // SRAM port and handshake outputs
  always_comb begin
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    req_ready  = 1'b0;
    case (state_q)
      StWr: begin
        sram_cs    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = cnt_q;
        sram_wdata = INIT_VALUE;
      end
`ifdef HPDCACHE_SRAM_SWEEP_VERIFY_EN
      StRd: begin
        sram_cs   = 1'b1;
        sram_addr = cnt_q;
      end
`endif
      StReady: begin
        req_ready = !init_req;
        if (accept) begin
          sram_cs    = 1'b1;
          sram_we    = req_we;
          sram_addr  = req_addr;
          sram_wdata = req_wdata;
        end
      end
      default: ;
    endcase
  end

  assign init_busy = (state_q != StReady);
  assign init_done = (state_q == StReady);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = sram_rdata;

endmodule

// File: tb/tb_hpdcache_sram_sweeper.sv
// Bench for hpdcache_sram_sweeper: two instances (DEPTH=16 and DEPTH=10), SRAM models,
// and a shadow-memory reference for functional traffic.
module tb_hpdcache_sram_sweeper;

`ifdef HPDCACHE_SRAM_SWEEP_VERIFY_EN
  localparam bit VerifyEn = 1'b1;
`else
  localparam bit VerifyEn = 1'b0;
`endif
  localparam int DA = 16;
  localparam int DB = 10;
  localparam logic [7:0] Init = 8'hA5;

  logic clk = 1'b0;
  logic rst_n;
  logic init_req, req_valid, req_we;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic corrupt;

  logic a_busy, a_done, a_req_ready, a_rsp_valid, a_cs, a_we, a_err;
  logic [3:0] a_addr, a_err_addr;
  logic [7:0] a_rsp_rdata, a_wdata, a_rdata;
  logic b_busy, b_done, b_req_ready, b_rsp_valid, b_cs, b_we, b_err;
  logic [3:0] b_addr, b_err_addr;
  logic [7:0] b_rsp_rdata, b_wdata, b_rdata;

  logic [7:0] mem_a [16];
  logic [7:0] mem_b [16];
  logic [7:0] ref_mem [16];
  bit exp_rsp;
  logic [7:0] exp_data;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hpdcache_sram_sweeper #(.ADDR_SIZE(4), .DATA_SIZE(8), .DEPTH(DA), .INIT_VALUE(Init),
                          .INIT_ON_RESET(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .init_busy(a_busy), .init_done(a_done),
    .req_valid(req_valid), .req_ready(a_req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .sram_cs(a_cs),
    .sram_we(a_we), .sram_addr(a_addr), .sram_wdata(a_wdata), .sram_rdata(a_rdata),
    .err(a_err), .err_addr(a_err_addr)
  );

  hpdcache_sram_sweeper #(.ADDR_SIZE(4), .DATA_SIZE(8), .DEPTH(DB), .INIT_VALUE(Init),
                          .INIT_ON_RESET(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .init_req(1'b0), .init_busy(b_busy), .init_done(b_done),
    .req_valid(1'b0), .req_ready(b_req_ready), .req_we(1'b0), .req_addr(4'd0),
    .req_wdata(8'd0), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .sram_cs(b_cs),
    .sram_we(b_we), .sram_addr(b_addr), .sram_wdata(b_wdata), .sram_rdata(b_rdata),
    .err(b_err), .err_addr(b_err_addr)
  );

  // SRAM macro models, 1-cycle read latency; instance A can store a corrupted addr 5
  always @(posedge clk) begin
    if (a_cs) begin
      if (a_we) mem_a[a_addr] <= (corrupt && a_addr == 4'd5) ? 8'h00 : a_wdata;
      else a_rdata <= mem_a[a_addr];
    end
    if (b_cs) begin
      if (b_we) mem_b[b_addr] <= b_wdata;
      else b_rdata <= mem_b[b_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected port activity k cycles after edge 0 of a sweep (k = -1 is the START cycle)
  function automatic void sweep_exp(input int d, input int k, output bit cs, output bit we,
                                    output int addr, output bit busy);
    int r;
    r = VerifyEn ? 2 * d + 1 : d;
    cs = 1'b0;
    we = 1'b0;
    addr = 0;
    busy = (k < r);
    if (k >= 0 && k < d) begin
      cs = 1'b1;
      we = 1'b1;
      addr = k;
    end else if (VerifyEn && k >= d && k < 2 * d) begin
      cs = 1'b1;
      addr = k - d;
    end
  endfunction

  // Called inside the START cycle; returns at the negedge of the first READY cycle
  task automatic run_sweep(input bit with_b, input bit exp_err_a);
    int ra, rb, busy_cnt;
    bit cs, we, busy;
    int addr;
    ra = VerifyEn ? 2 * DA + 1 : DA;
    rb = VerifyEn ? 2 * DB + 1 : DB;
    busy_cnt = 0;
    for (int k = -1; k <= ra; k++) begin
      if (k >= 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      sweep_exp(DA, k, cs, we, addr, busy);
      check_eq("a_cs", a_cs, cs);
      if (cs) begin
        check_eq("a_we", a_we, we);
        check_eq("a_addr", a_addr, addr);
        if (we) check_eq("a_wdata", a_wdata, Init);
      end
      check_eq("a_busy", a_busy, busy);
      check_eq("a_done", a_done, !busy);
      check_eq("a_req_ready", a_req_ready, !busy);
      check_eq("a_rsp_valid", a_rsp_valid, 0);
      if (a_busy) busy_cnt++;
      if (with_b) begin
        sweep_exp(DB, k, cs, we, addr, busy);
        check_eq("b_cs", b_cs, cs);
        if (cs) begin
          check_eq("b_we", b_we, we);
          check_eq("b_addr", b_addr, addr);
        end
        check_eq("b_done", b_done, !busy);
        check_eq("b_req_ready", b_req_ready, !busy);
        if (k == rb) check_eq("b_err", b_err, 0);
      end
    end
    check_eq("a_busy_cycles", busy_cnt, ra + 1);
    check_eq("a_err", a_err, exp_err_a && VerifyEn);
    check_eq("a_err_addr", a_err_addr, (exp_err_a && VerifyEn) ? 5 : 0);
  endtask

  // One functional cycle on instance A; entered and left just after a rising edge
  task automatic func_cycle(input bit v, input bit we, input logic [3:0] addr,
                            input logic [7:0] wd);
    req_valid = v;
    req_we = we;
    req_addr = addr;
    req_wdata = wd;
    @(negedge clk);
    check_eq("rsp_valid", a_rsp_valid, exp_rsp);
    if (exp_rsp) check_eq("rsp_rdata", a_rsp_rdata, exp_data);
    check_eq("f_req_ready", a_req_ready, 1);
    check_eq("f_cs", a_cs, v);
    if (v) begin
      check_eq("f_we", a_we, we);
      check_eq("f_addr", a_addr, addr);
      if (we) check_eq("f_wdata", a_wdata, wd);
    end
    exp_rsp = v && !we;
    if (v && !we) exp_data = ref_mem[addr];
    if (v && we) ref_mem[addr] = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    init_req = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    corrupt = 1'b1;
    exp_rsp = 1'b0;
    exp_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(1'b1, 1'b1);
    corrupt = 1'b0;

    // init_req with a same-cycle read: read refused, err cleared, full sweep follows
    @(posedge clk);
    #1;
    init_req = 1'b1;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 4'd2;
    #1;
    check_eq("init_req_ready", a_req_ready, 0);
    check_eq("init_req_cs", a_cs, 0);
    @(posedge clk);
    #1;
    init_req = 1'b0;
    req_valid = 1'b0;
    check_eq("err_clr", a_err, 0);
    check_eq("err_addr_clr", a_err_addr, 0);
    check_eq("no_rsp_refused", a_rsp_valid, 0);
    run_sweep(1'b0, 1'b0);

    // Functional traffic against a shadow memory
    for (int i = 0; i < 16; i++) ref_mem[i] = Init;
    exp_rsp = 1'b0;
    @(posedge clk);
    #1;
    func_cycle(1'b1, 1'b1, 4'd3, 8'h3C);
    func_cycle(1'b1, 1'b0, 4'd3, 8'h00);
    func_cycle(1'b0, 1'b0, 4'd0, 8'h00);
    for (int i = 0; i < 300; i++)
      func_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 8'($urandom));

    // Read accepted, then init_req next cycle: trailing response still delivered
    func_cycle(1'b1, 1'b0, 4'($urandom_range(0, 15)), 8'h00);
    init_req = 1'b1;
    #1;
    check_eq("trail_rsp_valid", a_rsp_valid, 1);
    check_eq("trail_rsp_rdata", a_rsp_rdata, exp_data);
    check_eq("trail_req_ready", a_req_ready, 0);
    check_eq("trail_cs", a_cs, 0);
    @(posedge clk);
    #1;
    init_req = 1'b0;
    run_sweep(1'b0, 1'b0);

    // Reset during the write to addr 7, then sweep restarts from 0
    @(posedge clk);
    #1;
    init_req = 1'b1;
    @(posedge clk);
    #1;
    init_req = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check_eq("mid_cs", a_cs, 1);
    check_eq("mid_addr", a_addr, 7);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_cs", a_cs, 0);
    check_eq("rst_busy", a_busy, 1);
    check_eq("rst_rsp_valid", a_rsp_valid, 0);
    check_eq("rst_err", a_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hpdcache_sram_sweeper.md
# hpdcache_sram_sweeper

Request-side initiator for a single-port HPDcache SRAM macro port (`cs`/`we`/`addr`/`wdata`/`rdata`, 1-cycle read latency). Cache SRAMs are not initialized by the macro, so this block drives the port with a sequential write sweep of `INIT_VALUE` to every entry after reset or on request. Once the sweep completes, it passes functional read/write requests from the cache controller through to the macro. It sits between a cache array controller (tag/state arrays) and one SRAM instance.

## Interface
- `ADDR_SIZE`, 0: SRAM address width; must be ≥1.
- `DATA_SIZE`, 0: SRAM data width; must be ≥1.
- `DEPTH`, 2**ADDR_SIZE: number of entries swept; 1 ≤ DEPTH ≤ 2**ADDR_SIZE.
- `INIT_VALUE`, '0: DATA_SIZE-bit value written to every entry.
- `INIT_ON_RESET`, 1: 1 = start a sweep automatically after reset; 0 = come out of reset in READY.

Ports:
- `clk` in 1: clock; everything is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `init_req` in 1: single-cycle pulse that requests a new sweep.
- `init_busy` out 1: high while a sweep (and verify pass) is in progress.
- `init_done` out 1: high in READY.
- `req_valid` in 1: functional request valid.
- `req_ready` out 1: functional request accepted when high with `req_valid`.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_SIZE: functional address.
- `req_wdata` in DATA_SIZE: functional write data.
- `rsp_valid` out 1: read data valid; one cycle after the read is accepted.
- `rsp_rdata` out DATA_SIZE: read data, equal to `sram_rdata`.
- `sram_cs` out 1: macro chip select.
- `sram_we` out 1: macro write enable.
- `sram_addr` out ADDR_SIZE: macro address.
- `sram_wdata` out DATA_SIZE: macro write data.
- `sram_rdata` in DATA_SIZE: macro read data, valid the cycle after a read with `cs`=1 and `we`=0.
- `err` out 1: verify mismatch, sticky (see Configuration).
- `err_addr` out ADDR_SIZE: first mismatching address.

## Operation
- FSM states: START, WR, RD, CHK, READY. RD and CHK exist only with the verify macro.
- Reset values:
  - state = START if INIT_ON_RESET else READY.
  - addr counter = 0, `rsp_valid` = 0, `err` = 0, `err_addr` = 0.
- START drives `sram_cs`=0, then moves to WR unconditionally.
- WR:
  - Drives `sram_cs`=1, `sram_we`=1, `sram_addr`=counter, `sram_wdata`=INIT_VALUE.
  - Counter increments each cycle.
  - At counter == DEPTH-1: counter clears to 0 and the FSM moves to READY (or to RD with the macro).
  - Wrap is by compare, not by overflow, so non-power-of-two DEPTH is supported.
- READY:
  - `req_ready` = !`init_req`.
  - On `req_valid`&&`req_ready`, `sram_*` mirror `req_*` combinationally with `sram_cs`=1. Otherwise `sram_cs`=0.
  - `rsp_valid` is set to 1 on the edge after an accepted read, 0 otherwise.
- `init_req` in READY:
  - Moves the FSM to START and clears `err`/`err_addr`.
  - A functional request in the same cycle is not accepted.
  - A read accepted in the previous cycle still gets its `rsp_valid` response.
- `init_req` outside READY is ignored.
- `init_busy` = (state != READY); `init_done` = (state == READY).
- `req_ready`=0 and `rsp_valid`=0 in all non-READY states, except the single trailing response described above.

## Timing
- Edge 0 is the first rising edge with `rst_n` high.
- With INIT_ON_RESET=1:
  - Edge 0: START→WR.
  - Cycle after edge k (k = 0..DEPTH-1) writes address k.
  - Edge DEPTH: enter READY, `init_done`=1.
  - A sweep takes DEPTH+1 cycles from START.
- Functional read latency is 1 cycle; throughput is 1 request per cycle in READY.
- Reset asserted mid-sweep: outputs return to reset values immediately. The sweep restarts from address 0 after deassertion when INIT_ON_RESET=1.

## Configuration
- Macro: `HPDCACHE_SRAM_SWEEP_VERIFY_EN`.
- Defined:
  - After WR, RD issues reads of addresses 0..DEPTH-1, one per cycle: `sram_cs`=1, `sram_we`=0.
  - Each `sram_rdata` is compared to INIT_VALUE on the following cycle.
  - CHK is one drain cycle that compares the last read.
  - On the first mismatch: `err`=1 and `err_addr`=address. Later mismatches do not update `err_addr`.
  - READY is entered at edge 2·DEPTH+1.
- Not defined:
  - WR→READY directly.
  - `err` and `err_addr` are tied to 0.
  - No RD/CHK logic is synthesized.

## Test plan
- ADDR_SIZE=4, DEPTH=16, INIT_VALUE=8'hA5: release reset → writes to addr 0..15 with wdata A5 on consecutive cycles, `init_done`=1 at edge 16, `req_ready`=0 throughout.
- DEPTH=10, ADDR_SIZE=4: release reset → last write is to addr 9, no write to addr 10..15, READY at edge 10.
- In READY: write addr 3 = 8'h3C, then read addr 3 → `rsp_valid`=1 one cycle after the read is accepted with `rsp_rdata`=8'h3C. A read issued the same cycle as `init_req` is not accepted (`req_ready`=0).
- Read accepted at cycle N, `init_req` at N+1 → `rsp_valid` at N+1, then a full sweep from addr 0, `init_busy`=1 for 17 cycles (DEPTH=16).
- Assert `rst_n`=0 during the write to addr 7 → `sram_cs`=0 immediately; after release, the sweep restarts at addr 0.
- Verify macro defined, memory model corrupts addr 5 to 8'h00 → `err`=1 and `err_addr`=5 at READY entry (edge 33). `init_req` clears `err`.
